// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse receiver: frame FSM states,
// header-byte bit positions and the frame geometry.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

    // Bit positions inside the first (header) byte of a mouse packet.
    localparam int SYNC_BIT = 3;
    localparam int XSIGN    = 4;
    localparam int YSIGN    = 5;
    localparam int XOVF     = 6;
    localparam int YOVF     = 7;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = FRAME_BITS - 3;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises the PS/2 pins, glitch-filters the clock line and emits a
// one-cycle strobe on each filtered falling edge; synced data is passed through.
module ps2_line_filter #(
    parameter int FILTER_CYCLES = 8
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic strobe_o,
    output logic data_o
);

    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic       clk_s1_q, clk_s2_q;
    logic       dat_s1_q, dat_s2_q;
    logic       filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic       strobe_q, strobe_d;

    // The filtered clock only moves after FILTER_CYCLES consecutive disagreeing samples.
    always_comb begin
        filt_d   = filt_q;
        cnt_d    = '0;
        strobe_d = 1'b0;
        if (clk_s2_q != filt_q) begin
            if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
                filt_d   = clk_s2_q;
                strobe_d = filt_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            filt_q   <= 1'b1;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
            filt_q   <= filt_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe_o = strobe_q;
    assign data_o   = dat_s2_q;

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: deframes 11-bit frames and assembles 3-byte packets
// into signed 9-bit deltas and button state with a one-cycle valid strobe.
module ps2_mouse_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       packet_valid,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic       btn_left,
    output logic       btn_right,
    output logic       btn_middle,
    output logic       x_ovf,
    output logic       y_ovf,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic strobe;
    logic bit_in;

    ps2_line_filter #(
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filter (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .strobe_o(strobe),
        .data_o  (bit_in)
    );

    frame_state_t  state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    b0_q, b0_d;
    logic [7:0]    b1_q, b1_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          pv_q, pv_d;
    logic          fe_q, fe_d;
    logic [8:0]    dx_q, dx_d;
    logic [8:0]    dy_q, dy_d;
    logic [2:0]    btn_q, btn_d;
    logic          xo_q, xo_d;
    logic          yo_q, yo_d;
    logic          byte_done;
    logic          byte_bad;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        idx_d     = idx_q;
        b0_d      = b0_q;
        b1_d      = b1_q;
        tmo_d     = tmo_q;
        pv_d      = 1'b0;
        fe_d      = 1'b0;
        dx_d      = dx_q;
        dy_d      = dy_q;
        btn_d     = btn_q;
        xo_d      = xo_q;
        yo_d      = yo_q;
        byte_done = 1'b0;
        byte_bad  = 1'b0;

        if (strobe) begin
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    if (!bit_in) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {bit_in, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = bit_in;
                    state_d  = STOP;
                end
                STOP: begin
                    if (odd_parity_ok(shift_q, parity_q) && bit_in) begin
                        byte_done = 1'b1;
                    end else begin
                        byte_bad = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE || idx_q != 2'd0) begin
            // A stalled frame or packet is abandoned silently; outputs keep their values.
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                tmo_d   = '0;
                state_d = IDLE;
                idx_d   = 2'd0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end

        if (byte_bad) begin
            fe_d  = 1'b1;
            idx_d = 2'd0;
        end

        if (byte_done) begin
            case (idx_q)
                2'd0: begin
                    if (shift_q[SYNC_BIT]) begin
                        b0_d  = shift_q;
                        idx_d = 2'd1;
                    end
                end
                2'd1: begin
                    b1_d  = shift_q;
                    idx_d = 2'd2;
                end
                2'd2: begin
                    idx_d = 2'd0;
                    if (b0_q[SYNC_BIT]) begin
                        pv_d  = 1'b1;
                        dx_d  = {b0_q[XSIGN], b1_q};
                        dy_d  = {b0_q[YSIGN], shift_q};
                        btn_d = b0_q[2:0];
                        xo_d  = b0_q[XOVF];
                        yo_d  = b0_q[YOVF];
                    end
                end
                default: idx_d = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            idx_q     <= 2'd0;
            b0_q      <= '0;
            b1_q      <= '0;
            tmo_q     <= '0;
            pv_q      <= 1'b0;
            fe_q      <= 1'b0;
            dx_q      <= '0;
            dy_q      <= '0;
            btn_q     <= '0;
            xo_q      <= 1'b0;
            yo_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            idx_q     <= idx_d;
            b0_q      <= b0_d;
            b1_q      <= b1_d;
            tmo_q     <= tmo_d;
            pv_q      <= pv_d;
            fe_q      <= fe_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            btn_q     <= btn_d;
            xo_q      <= xo_d;
            yo_q      <= yo_d;
        end
    end

    assign packet_valid = pv_q;
    assign frame_err    = fe_q;
    assign dx           = dx_q;
    assign dy           = dy_q;
    assign btn_left     = btn_q[0];
    assign btn_right    = btn_q[1];
    assign btn_middle   = btn_q[2];
    assign x_ovf        = xo_q;
    assign y_ovf        = yo_q;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Directed bench for ps2_mouse_rx: a packet-level model predicts every
// packet_valid / frame_err pulse (cycle and payload) and the held outputs.
module tb_ps2_mouse_rx;

    localparam int FILT = 8;
    localparam int TMO  = 2000;
    localparam int HALF = 40;
    localparam int GAP  = 200;

    typedef struct {
        int         cyc;
        bit         is_err;
        logic [8:0] dx;
        logic [8:0] dy;
        logic [4:0] fl;   // {y_ovf, x_ovf, middle, right, left}
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk_pin = 1'b1;
    logic       ps2_data_pin = 1'b1;
    logic       packet_valid, frame_err;
    logic       btn_left, btn_right, btn_middle, x_ovf, y_ovf;
    logic [8:0] dx, dy;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   pv_cnt = 0;
    int   fe_cnt = 0;
    bit   checking = 0;
    exp_t exp_q[$];
    exp_t cur;

    logic [8:0] h_dx = '0;
    logic [8:0] h_dy = '0;
    logic [4:0] h_fl = '0;
    int         m_idx = 0;
    logic [7:0] m_b0 = '0;
    logic [7:0] m_b1 = '0;

    ps2_mouse_rx #(
        .FILTER_CYCLES (FILT),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_in      (clk),
        .rst_in      (rst_n),
        .ps2_clk     (ps2_clk_pin),
        .ps2_data    (ps2_data_pin),
        .packet_valid(packet_valid),
        .dx          (dx),
        .dy          (dy),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_middle  (btn_middle),
        .x_ovf       (x_ovf),
        .y_ovf       (y_ovf),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every cycle: pulses must match the predicted events, data outputs must hold the last packet.
    always @(negedge clk) begin
        if (checking) begin
            if (packet_valid === 1'b1 || frame_err === 1'b1) begin
                if (packet_valid === 1'b1) pv_cnt++;
                if (frame_err === 1'b1) fe_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {30'd0, packet_valid, frame_err}, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("event_cycle", cyc, cur.cyc);
                    chk("event_kind", {30'd0, packet_valid, frame_err}, cur.is_err ? 32'd1 : 32'd2);
                    if (!cur.is_err) begin
                        h_dx = cur.dx;
                        h_dy = cur.dy;
                        h_fl = cur.fl;
                    end
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                chk("missing_event", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            chk("held_outputs", {dx, dy, y_ovf, x_ovf, btn_middle, btn_right, btn_left},
                {h_dx, h_dy, h_fl});
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit bad);
        logic [10:0] f;
        exp_t        e;
        bit          push;
        int          fc;
        f    = {1'b1, (~^b) ^ bad, b, 1'b0};
        push = 0;
        e    = '{default: 0};
        if (bad) begin
            push     = 1;
            e.is_err = 1;
            m_idx    = 0;
        end else if (m_idx == 0) begin
            if (b[3]) begin
                m_b0  = b;
                m_idx = 1;
            end
        end else if (m_idx == 1) begin
            m_b1  = b;
            m_idx = 2;
        end else begin
            push  = 1;
            e.dx  = {m_b0[4], m_b1};
            e.dy  = {m_b0[5], b};
            e.fl  = {m_b0[7], m_b0[6], m_b0[2:0]};
            m_idx = 0;
        end
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1 ps2_data_pin = f[i];
            repeat (10) @(posedge clk);
            #1 ps2_clk_pin = 1'b0;
            fc = cyc;
            // Stop-bit falling edge: strobe lands 2+FILT cycles later, result one cycle after that.
            if (i == 10 && push) begin
                e.cyc = fc + 2 + FILT + 1;
                exp_q.push_back(e);
            end
            repeat (HALF) @(posedge clk);
            #1 ps2_clk_pin = 1'b1;
            repeat (HALF) @(posedge clk);
        end
        @(posedge clk); #1 ps2_data_pin = 1'b1;
        repeat (GAP) @(posedge clk);
    endtask

    task automatic check_packet(input string name, input int pv0, input int fe0,
                                input logic [8:0] edx, input logic [8:0] edy,
                                input logic [2:0] ebtn, input int epv, input int efe);
        chk({name, "_pv_count"}, pv_cnt - pv0, epv);
        chk({name, "_fe_count"}, fe_cnt - fe0, efe);
        chk({name, "_dx"}, {23'd0, dx}, {23'd0, edx});
        chk({name, "_dy"}, {23'd0, dy}, {23'd0, edy});
        chk({name, "_btn"}, {29'd0, btn_middle, btn_right, btn_left}, {29'd0, ebtn});
        chk({name, "_ovf"}, {30'd0, y_ovf, x_ovf}, 32'd0);
    endtask

    initial begin
        int pv0, fe0;
        logic [10:0] pf;

        // Reset with the pins toggling: outputs must stay zero throughout.
        repeat (2) @(posedge clk);
        #1 checking = 1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            ps2_clk_pin  = 1'($urandom_range(0, 1));
            ps2_data_pin = 1'($urandom_range(0, 1));
        end
        chk("reset_outputs", {8'd0, packet_valid, frame_err, dx, dy, y_ovf, x_ovf,
            btn_middle, btn_right, btn_left}, 32'd0);
        @(posedge clk); #1;
        ps2_clk_pin  = 1'b1;
        ps2_data_pin = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (50) @(posedge clk);
        chk("idle_after_reset", {30'd0, packet_valid, frame_err}, 32'd0);

        // Nominal packet.
        pv0 = pv_cnt; fe0 = fe_cnt;
        send_byte(8'h29, 0);
        send_byte(8'h05, 0);
        send_byte(8'hFB, 0);
        check_packet("nominal", pv0, fe0, 9'h005, 9'h1FB, 3'b001, 1, 0);

        // Parity error mid-packet, then a clean packet.
        pv0 = pv_cnt; fe0 = fe_cnt;
        send_byte(8'h29, 0);
        send_byte(8'h05, 1);
        send_byte(8'h08, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        check_packet("parity", pv0, fe0, 9'h001, 9'h002, 3'b000, 1, 1);

        // Header without sync bit is dropped silently.
        pv0 = pv_cnt; fe0 = fe_cnt;
        send_byte(8'h00, 0);
        send_byte(8'h18, 0);
        send_byte(8'h10, 0);
        send_byte(8'h20, 0);
        check_packet("resync", pv0, fe0, 9'h110, 9'h020, 3'b000, 1, 0);

        // Stalled packet times out.
        pv0 = pv_cnt; fe0 = fe_cnt;
        send_byte(8'h08, 0);
        send_byte(8'h03, 0);
        repeat (TMO + 1000) @(posedge clk);
        m_idx = 0;
        send_byte(8'h09, 0);
        send_byte(8'h04, 0);
        send_byte(8'h06, 0);
        check_packet("timeout", pv0, fe0, 9'h004, 9'h006, 3'b001, 1, 0);

        // Short clock glitch with data low must not start a frame.
        pv0 = pv_cnt; fe0 = fe_cnt;
        @(posedge clk); #1 ps2_data_pin = 1'b0;
        repeat (5) @(posedge clk);
        #1 ps2_clk_pin = 1'b0;
        repeat (3) @(posedge clk);
        #1 ps2_clk_pin = 1'b1;
        repeat (5) @(posedge clk);
        #1 ps2_data_pin = 1'b1;
        repeat (50) @(posedge clk);
        send_byte(8'h0A, 0);
        send_byte(8'h07, 0);
        send_byte(8'h09, 0);
        check_packet("glitch", pv0, fe0, 9'h007, 9'h009, 3'b010, 1, 0);

        // Reset in the middle of a packet and byte.
        pv0 = pv_cnt; fe0 = fe_cnt;
        send_byte(8'h29, 0);
        pf = {1'b1, ~^8'h05, 8'h05, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1 ps2_data_pin = pf[i];
            repeat (10) @(posedge clk);
            #1 ps2_clk_pin = 1'b0;
            repeat (HALF) @(posedge clk);
            #1 ps2_clk_pin = 1'b1;
            repeat (HALF) @(posedge clk);
        end
        @(posedge clk); #1;
        h_dx = '0; h_dy = '0; h_fl = '0;
        m_idx = 0;
        exp_q.delete();
        rst_n = 1'b0;
        ps2_data_pin = 1'b1;
        repeat (5) @(posedge clk);
        chk("midreset_outputs", {9'd0, dx, dy, y_ovf, x_ovf, btn_middle, btn_right, btn_left}, 32'd0);
        #1 rst_n = 1'b1;
        repeat (50) @(posedge clk);
        send_byte(8'h0C, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        check_packet("midreset", pv0, fe0, 9'h002, 9'h003, 3'b100, 1, 0);

        repeat (20) @(posedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        checking = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
